if_id_pipe_reg: RTL
===================

Name: if_id_pipe_reg

Overview:
- Parametrised IF/ID pipeline register for the five-stage CPU.
- Carries instruction word and PC from fetch to decode.
- Adds, over the plain pass-through register:
  - valid/ready handshake, so decode can stall fetch;
  - a 2-entry skid buffer, so a registered upstream ready loses nothing;
  - a synchronous flush for branch/jump squash;
  - NOP bubble output when the stage is empty.

Parameters:
- INSTR_W, 32, instruction word width in bits.
- ADDR_W, 32, PC width in bits.
- NOP_INSTR, 32'h0000_0000, word presented on out_instr when the stage holds no valid entry.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered (no combinational path from out_ready).
- in_instr  in  INSTR_W  fetched instruction.
- in_addrs  in  ADDR_W  PC of fetched instruction.
- flush  in  1  squash all held entries and any same-cycle input.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode consumes the entry this cycle.
- out_instr  out  INSTR_W  held instruction, or NOP_INSTR when out_valid=0.
- out_addrs  out  ADDR_W  held PC, or 0 when out_valid=0.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage: main register (drives outputs) plus skid register. State is encoded by valid bits.
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - TWO: main=1, skid=1.
- Handshake definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - All transfers happen on the rising clk edge.
- Transitions (when flush=0):
  - EMPTY: accept -> ONE (data into main). Otherwise stay.
  - ONE, accept & pop: main <= input; stay ONE.
  - ONE, accept & !pop: skid <= input -> TWO.
  - ONE, !accept & pop: -> EMPTY.
  - ONE, otherwise: hold.
  - TWO, pop: main <= skid -> ONE. No accept is possible, since in_ready=0.
  - TWO, otherwise: hold.
- in_ready = !skid_valid, registered.
  - Deasserts the cycle after entering TWO.
  - Reasserts the cycle after leaving TWO.
- Latency: input accepted at edge N appears on outputs after edge N (1 cycle) when entering an empty or popping main.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- Output muxing:
  - out_valid = main_valid.
  - out_instr = main_valid ? main_instr : NOP_INSTR.
  - out_addrs = main_valid ? main_addrs : 0.
- Flush (highest priority):
  - At the next edge both valids clear -> EMPTY. Any same-cycle accept or pop is ignored and the input is discarded.
  - in_ready = 1 the following cycle.
  - Data registers need not clear; outputs show NOP and 0 through the mux.
- Reset (async, rst=1):
  - Immediately forces EMPTY, in_ready=1, out_valid=0, out_instr=NOP_INSTR, out_addrs=0, occupancy=0.
  - Applies mid-transfer, independent of clk.
  - Release is synchronous to the next edge with normal operation.
- occupancy = main_valid + skid_valid.
- Out-of-range widths: none. Data are passed bit-exact and no arithmetic is performed on PC.

Test Plan:
- Reset/idle: assert rst mid-cycle with entries held -> same cycle out_valid=0, out_instr=NOP_INSTR (0x0), out_addrs=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, in_valid=1 with (0x8C010004, 0x100), (0x20420001, 0x104), (0x00431020, 0x108) on consecutive edges -> each appears one cycle later in order, occupancy stays 1, in_ready stays 1.
- Stall/skid: after one entry (0xAAAA0001, 0x200) is held, drop out_ready and send (0xBBBB0002, 0x204).
  - occupancy=2; in_ready=0 the next cycle; outputs hold 0xAAAA0001.
  - Raise out_ready -> 0xAAAA0001 then 0xBBBB0002 pop on successive edges; in_ready returns to 1.
- Flush: with two entries held, pulse flush together with in_valid=1 (0xCCCC0003, 0x300) and out_ready=1.
  - Next cycle out_valid=0, out_instr=NOP_INSTR, occupancy=0.
  - 0xCCCC0003 never appears at the output.
- Parameter sweep: INSTR_W=16, ADDR_W=12, NOP_INSTR=16'h7000, all entries empty -> out_instr=0x7000.
  - Push (0x1234, 0xABC) -> outputs 0x1234/0xABC after 1 cycle.
- Random back-pressure: 2000 cycles with random in_valid/out_ready and flush at 1% -> scoreboard confirms no loss or duplication outside flush, in-order delivery, and occupancy never exceeds 2.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register for the five-stage CPU.
// Carries the fetched instruction word and its PC from fetch to decode. It has a
// valid/ready handshake on both sides, a two-entry skid buffer behind a
// registered in_ready, a synchronous flush, and NOP/zero outputs when empty.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   fetch-side handshake (in_ready is a flop output)
//   in_instr, in_addrs  fetched instruction and its PC
//   flush               squash held entries and any same-cycle input
//   out_valid/out_ready decode-side handshake
//   out_instr, out_addrs  head entry, or NOP_INSTR / 0 when empty
//   occupancy           number of entries held (0..2)
//
// state | meaning
// EMPTY | main=0 skid=0, outputs show NOP
// ONE   | main=1 skid=0, head entry in main
// TWO   | main=1 skid=1, younger entry parked in skid, in_ready low
module if_id_pipe_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 ADDR_W    = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_addrs,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_addrs,
  output logic [1:0]         occupancy
);

  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [ADDR_W-1:0]  main_addrs_q, main_addrs_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_addrs_q, skid_addrs_d;

  logic accept;
  logic pop;

  always_comb begin
    accept       = in_valid & in_ready_q;
    pop          = main_valid_q & out_ready;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_instr_d = main_instr_q;
    main_addrs_d = main_addrs_q;
    skid_instr_d = skid_instr_q;
    skid_addrs_d = skid_addrs_q;

    if (flush) begin
      // Data registers are left alone; the output mux hides stale contents.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (accept) begin
            main_valid_d = 1'b1;
            main_instr_d = in_instr;
            main_addrs_d = in_addrs;
          end
        end
        2'b10: begin
          if (accept && pop) begin
            main_instr_d = in_instr;
            main_addrs_d = in_addrs;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_instr_d = in_instr;
            skid_addrs_d = in_addrs;
          end else if (pop) begin
            main_valid_d = 1'b0;
          end
        end
        2'b11: begin
          // in_ready is low here, so no accept can coincide with the pop.
          if (pop) begin
            skid_valid_d = 1'b0;
            main_instr_d = skid_instr_q;
            main_addrs_d = skid_addrs_q;
          end
        end
        default: begin
          // skid without main is unreachable; fall back to empty.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end

    // Registered ready: next cycle's ready reflects next cycle's skid state,
    // so there is no combinational path from out_ready to in_ready.
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    main_instr_q <= main_instr_d;
    main_addrs_q <= main_addrs_d;
    skid_instr_q <= skid_instr_d;
    skid_addrs_q <= skid_addrs_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_instr = main_valid_q ? main_instr_q : NOP_INSTR;
  assign out_addrs = main_valid_q ? main_addrs_q : '0;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
